// File: rtl/keypad_scanner_pkg.sv
// Shared encodings and geometry for the 4x4 hex keypad scanner.
package keypad_scanner_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int COL_IDX_W  = 2;
  localparam int ROW_IDX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kpState_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } scanRes_e;

endpackage

// File: rtl/keypad_scan_timebase.sv
// Column timebase: prescaler, column index, one-cold strobe, tick and scan_done.
module keypad_scan_timebase
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 2048
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [NUM_COLS-1:0]  col,
  output logic [COL_IDX_W-1:0] colIdx,
  output logic                 tick,
  output logic                 scanDone
);
  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] presc;

  assign tick     = (presc == PW'(SCAN_DIV - 1));
  assign scanDone = tick && (colIdx == COL_IDX_W'(NUM_COLS - 1));

  // Prescaler wraps after SCAN_DIV cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  // Column index steps once per tick, wrapping 3->0 naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     colIdx <= '0;
    else if (tick) colIdx <= colIdx + COL_IDX_W'(1);
  end

  // One-cold strobe: the driven column is pulled low.
  always_comb col = ~(NUM_COLS'(1) << colIdx);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with whole-scan debounce and valid/ack key events.
// Optional macro KEYPAD_AUTOREPEAT_EN re-emits a held key every REPEAT_SCANS scans.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 2048,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_ROWS-1:0]   row,
  output logic [NUM_COLS-1:0]   col,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ack,
  output logic                  key_held,
  output logic                  overrun
);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || REPEAT_SCANS < 1) begin : gBadParams
    $error("keypad_scanner: illegal parameter values");
  end

  logic [COL_IDX_W-1:0] colIdx;
  logic                 tick, scanDone;

  keypad_scan_timebase #(.SCAN_DIV(SCAN_DIV)) uTimebase (
    .clock    (clock),
    .reset    (reset),
    .col      (col),
    .colIdx   (colIdx),
    .tick     (tick),
    .scanDone (scanDone)
  );

  // Two-flop synchroniser; idle rows read as all-high.
  logic [NUM_ROWS-1:0] rowMeta, rowSync;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rowMeta <= '1;
      rowSync <= '1;
    end else begin
      rowMeta <= row;
      rowSync <= rowMeta;
    end
  end

  // Hits so far this scan: count saturates at 2 (= many), code valid when count is 1.
  logic [1:0]            accCnt, hitCnt, totCnt;
  logic [2:0]            sumCnt;
  logic [ROW_IDX_W-1:0]  hitRow;
  logic [KEY_CODE_W-1:0] accCode, totCode;
  scanRes_e              scanRes;

  // Fold the current column's sample into the running scan result.
  always_comb begin
    hitCnt = 2'd0;
    hitRow = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rowSync[r]) begin
        hitRow = ROW_IDX_W'(r);
        if (hitCnt != 2'd2) hitCnt = hitCnt + 2'd1;
      end
    end
    sumCnt  = {1'b0, accCnt} + {1'b0, hitCnt};
    totCnt  = (sumCnt > 3'd2) ? 2'd2 : sumCnt[1:0];
    totCode = (accCnt == 2'd1) ? accCode : {hitRow, colIdx};
    scanRes = (totCnt == 2'd0) ? RES_NONE : (totCnt == 2'd1) ? RES_SINGLE : RES_MULTI;
  end

  // Accumulate on each tick; restart on the scan's last column.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      accCnt  <= '0;
      accCode <= '0;
    end else if (scanDone) begin
      accCnt  <= '0;
      accCode <= '0;
    end else if (tick) begin
      accCnt  <= totCnt;
      accCode <= totCode;
    end
  end

  kpState_e              state, stateN;
  logic [CNT_W-1:0]      cnt, cntN;
  logic [KEY_CODE_W-1:0] cand, candN;
  logic                  heldN, emit, evPend;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  logic [REP_W-1:0] repCnt, repCntN;
`endif

  // Debounce FSM state, counters and held level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cand     <= '0;
      key_held <= 1'b0;
      evPend   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      repCnt   <= '0;
`endif
    end else begin
      state    <= stateN;
      cnt      <= cntN;
      cand     <= candN;
      key_held <= heldN;
      evPend   <= emit;
`ifdef KEYPAD_AUTOREPEAT_EN
      repCnt   <= repCntN;
`endif
    end
  end

  // Next-state: acts only on completed scans.
  always_comb begin
    stateN = state;
    cntN   = cnt;
    candN  = cand;
    heldN  = key_held;
    emit   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    repCntN = repCnt;
`endif
    if (scanDone) begin
      case (state)
        ST_IDLE: begin
          if (scanRes == RES_SINGLE) begin
            stateN = ST_DEBOUNCE;
            candN  = totCode;
            cntN   = CNT_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (scanRes == RES_SINGLE && totCode == cand) begin
            if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
              stateN = ST_PRESSED;
              heldN  = 1'b1;
              emit   = 1'b1;
              cntN   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              repCntN = '0;
`endif
            end else begin
              cntN = cnt + CNT_W'(1);
            end
          end else if (scanRes == RES_SINGLE) begin
            candN = totCode;
            cntN  = CNT_W'(1);
          end else begin
            stateN = ST_IDLE;
            cntN   = '0;
          end
        end
        ST_PRESSED: begin
          if (scanRes == RES_NONE) begin
            stateN = ST_RELEASE;
            cntN   = CNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
            repCntN = '0;
          end else if (scanRes == RES_SINGLE && totCode == cand) begin
            if (repCnt == REP_W'(REPEAT_SCANS - 1)) begin
              repCntN = '0;
              emit    = 1'b1;
            end else begin
              repCntN = repCnt + REP_W'(1);
            end
`endif
          end
        end
        ST_RELEASE: begin
          if (scanRes == RES_NONE) begin
            if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
              stateN = ST_IDLE;
              heldN  = 1'b0;
              cntN   = '0;
            end else begin
              cntN = cnt + CNT_W'(1);
            end
          end else begin
            // Bounce back to held without a new event.
            stateN = ST_PRESSED;
            cntN   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            repCntN = '0;
`endif
          end
        end
        default: stateN = ST_IDLE;
      endcase
    end
  end

  // Event register: a pending event beats a same-cycle ack; unacked overwrite flags overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (evPend) begin
      key_code  <= cand;
      key_valid <= 1'b1;
      if (key_valid && !key_ack) overrun <= 1'b1;
    end else if (key_ack && key_valid) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: scan-level reference model plus directed keypad patterns.
module tb_keypad_scanner;
  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int RS   = 2;
  localparam int SCAN = 4 * SD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        key_ack = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held, overrun;

  int compared = 0;
  int mismatched = 0;
  bit armed = 1'b0;

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RS)) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Reference model: e = clock edges since reset; debounce expressed as run lengths of scans.
  typedef struct {
    int   e;
    logic held;
    int   cand;
    int   run;
    int   rel;
    int   rep;
    logic pend;
    int   pendCode;
    logic valid;
    int   code;
    logic ovr;
  } model_t;

  model_t m;

  function automatic model_t step(model_t cur, logic [15:0] k, logic ack);
    model_t n;
    int cnt;
    int code;
    n = cur;
    if (cur.pend) begin
      n.valid = 1'b1;
      n.code  = cur.pendCode;
      if (cur.valid && !ack) n.ovr = 1'b1;
    end else if (ack && cur.valid) begin
      n.valid = 1'b0;
      n.ovr   = 1'b0;
    end
    n.pend = 1'b0;
    if (cur.e % SCAN == SCAN - 1) begin
      cnt  = $countones(k);
      code = 0;
      for (int i = 0; i < 16; i++) if (k[i]) code = i;
      if (!cur.held) begin
        if (cnt == 1) begin
          n.run  = (cur.run > 0 && code == cur.cand) ? cur.run + 1 : 1;
          n.cand = code;
          if (n.run == DB) begin
            n.held = 1'b1; n.run = 0; n.rep = 0;
            n.pend = 1'b1; n.pendCode = code;
          end
        end else begin
          n.run = 0;
        end
      end else if (cnt == 0) begin
        n.rel = cur.rel + 1;
        n.rep = 0;
        if (n.rel == DB) begin
          n.held = 1'b0; n.rel = 0;
        end
      end else if (cur.rel > 0) begin
        n.rel = 0; n.rep = 0;
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      else if (cnt == 1 && code == cur.cand) begin
        n.rep = cur.rep + 1;
        if (n.rep == RS) begin
          n.rep = 0; n.pend = 1'b1; n.pendCode = cur.cand;
        end
      end
`endif
    end
    n.e = cur.e + 1;
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '{default: 0};
    else       m <= step(m, keys, key_ack);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (armed) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << ((m.e / SD) % 4));
      chk("col", 32'(col), 32'(ec));
      chk("key_valid", 32'(key_valid), 32'(m.valid));
      chk("key_code", 32'(key_code), 32'(m.code));
      chk("key_held", 32'(key_held), 32'(m.held));
      chk("overrun", 32'(overrun), 32'(m.ovr));
    end
  end

  task automatic scan(input logic [15:0] k, input int n, input int ackAt = -1);
    keys = k;
    for (int s = 0; s < n; s++)
      for (int i = 0; i < SCAN; i++) begin
        key_ack = (s == 0 && i == ackAt);
        @(negedge clock);
      end
    key_ack = 1'b0;
  endtask

  task automatic doReset();
    keys = '0;
    key_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_col", 32'(col), 32'h0000_000E);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
  endtask

  logic [3:0] colSeq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    armed = 1'b1;
    doReset();

    // Column strobe walks one-cold every SD clocks.
    keys = '0;
    for (int c = 1; c < 4; c++) begin
      repeat (SD) @(negedge clock);
      chk("col_walk", 32'(col), 32'(colSeq[c]));
    end
    repeat (SD) @(negedge clock);
    chk("col_wrap", 32'(col), 32'(colSeq[0]));

    // Clean press of key 6, ack, release.
    scan(16'h0040, 3);
    chk("t2_held", 32'(key_held), 32'd1);
    chk("t2_notyet", 32'(key_valid), 32'd0);
    scan(16'h0040, 1);
    chk("t2_valid", 32'(key_valid), 32'd1);
    chk("t2_code", 32'(key_code), 32'd6);
    scan(16'h0040, 1, 4);
    chk("t2_acked", 32'(key_valid), 32'd0);
    scan(16'h0000, 2);
    chk("t2_still_held", 32'(key_held), 32'd1);
    scan(16'h0000, 1);
    chk("t2_released", 32'(key_held), 32'd0);

    // Too-short press.
    scan(16'h0040, 2);
    scan(16'h0000, 3);
    chk("t3_valid", 32'(key_valid), 32'd0);
    chk("t3_held", 32'(key_held), 32'd0);

    // Two keys together never yield an event.
    scan(16'h0240, 4);
    scan(16'h0000, 1);
    chk("t4_valid", 32'(key_valid), 32'd0);
    chk("t4_held", 32'(key_held), 32'd0);

    // Unacked event overwritten by a second press.
    scan(16'h0040, 4);
    scan(16'h0000, 3);
    scan(16'h0200, 3);
    scan(16'h0200, 1);
    chk("t5_code", 32'(key_code), 32'd9);
    chk("t5_valid", 32'(key_valid), 32'd1);
    chk("t5_overrun", 32'(overrun), 32'd1);
    scan(16'h0200, 1, 4);
    chk("t5_ack_valid", 32'(key_valid), 32'd0);
    chk("t5_ack_overrun", 32'(overrun), 32'd0);
    scan(16'h0000, 3);

    // Ack in the same cycle as a new event: event wins, overrun untouched.
    scan(16'h0040, 4);
    scan(16'h0000, 3);
    scan(16'h0200, 3);
    scan(16'h0200, 1, 0);
    chk("t7_valid", 32'(key_valid), 32'd1);
    chk("t7_code", 32'(key_code), 32'd9);
    chk("t7_overrun", 32'(overrun), 32'd0);
    scan(16'h0200, 1, 4);
    scan(16'h0000, 3);

    // Reset during debounce drops the press.
    scan(16'h0040, 2);
    doReset();
    scan(16'h0040, 1);
    scan(16'h0000, 4);
    chk("t6_valid", 32'(key_valid), 32'd0);
    chk("t6_held", 32'(key_held), 32'd0);

    // Long hold: one event, or repeats every RS scans with autorepeat.
    scan(16'h0040, 3);
    scan(16'h0040, 5);
    chk("t8_held", 32'(key_held), 32'd1);
    chk("t8_code", 32'(key_code), 32'd6);
    scan(16'h0040, 1, 4);
    scan(16'h0000, 3);
    chk("t8_released", 32'(key_held), 32'd0);
    scan(16'h0000, 1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart of the 7-segment display driver. It strobes the columns of a 4x4 hex keypad one-cold, samples the row lines, and debounces over whole scans. It produces one 4-bit key code per press, using a valid/ack handshake toward the CPU/accelerator register interface.

Parameters:
SCAN_DIV, 2048, clock cycles each column is driven before advancing; must be >= 4.
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release; must be >= 2.
REPEAT_SCANS, 64, scans between auto-repeat events; used only with the optional feature.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
row  in  4  keypad rows, active-low, externally pulled up, asynchronous to clock
col  out  4  one-cold column strobe (0 = driven column)
key_code  out  4  accepted key, code = row_idx*4 + col_idx
key_valid  out  1  key_code holds an unacknowledged event
key_ack  in  1  single-cycle consume strobe
key_held  out  1  debounced "a key is down" level
overrun  out  1  sticky; an event was overwritten before ack

Behaviour:
- Reset values: col=4'b1110; key_code=0; key_valid=0; key_held=0; overrun=0; FSM=IDLE; all counters 0.
- Synchronisation: row passes through a 2-flop synchroniser before any use.
- Timebase:
  - Prescaler counts 0..SCAN_DIV-1 and wraps; tick is asserted when it equals SCAN_DIV-1.
  - The 2-bit col_idx advances on tick and wraps 3->0.
  - col is the one-cold decode of col_idx.
- Sampling: synchronised rows are sampled on tick, before col_idx advances, so they belong to the current column.
- Scan result: accumulated over col_idx 0..3 and evaluated on the tick with col_idx=3 (scan_done). The result is one of:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one row/column intersection low.
  - MULTI: more than one intersection low. MULTI never produces an event.
- FSM, evaluated only on scan_done (cnt = debounce counter):
  - IDLE: SINGLE -> DEBOUNCE, cand=code, cnt=1. Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> PRESSED and emit an event.
    - SINGLE(other) -> stay, cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED: key_held=1. NONE -> RELEASE, cnt=1. SINGLE or MULTI -> stay (no rollover events).
  - RELEASE:
    - NONE -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> IDLE and key_held=0.
    - Anything else -> PRESSED (bounce), no new event.
- key_held is registered and set/cleared in the same cycle as the state change.
- Event, a single cycle: key_code<=cand and key_valid<=1 in the cycle after scan_done.
  - If key_valid=1 and key_ack=0 in that cycle: key_code is overwritten and overrun<=1.
  - If key_ack=1 in the same cycle: the new event wins, key_valid stays 1, overrun is unchanged.
- key_ack with key_valid=1 clears key_valid and overrun on the next edge. key_ack with key_valid=0 is ignored.
- Latency: from a clean stable press to key_valid, at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- Reset mid-operation: the block returns immediately to the reset values and any pending event is lost.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: while in PRESSED with SINGLE(cand) still present, a repeat counter counts scans. Every REPEAT_SCANS scans it re-emits cand through the normal event path, with the same overrun rules. The counter clears when PRESSED is entered or the state is left.
- Undefined: exactly one event per press. No repeat counter is instantiated and REPEAT_SCANS is ignored.

Decomposition:
- Shared package/include holds:
  - FSM state encodings (IDLE, DEBOUNCE, PRESSED, RELEASE).
  - NUM_ROWS=4, NUM_COLS=4, KEY_CODE_W=4.
  - Scan-result encodings NONE, SINGLE, MULTI.
- One sub-module, keypad_scan_timebase: prescaler, col_idx counter, one-cold col decode, tick and scan_done outputs. The top level holds the synchroniser, scan accumulator, FSM and handshake.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
1. Assert reset mid-sim -> col=1110, key_valid=0, key_held=0, overrun=0, and col cycles 1110->1101->1011->0111 every 4 clocks.
2. Hold key row1/col2 (row=1101 whenever col=1011) -> key_valid=1, key_code=6, key_held=1 after the 3rd scan. Pulse key_ack -> key_valid=0 next cycle. Release -> key_held=0 after 3 NONE scans.
3. Key 6 present for only 2 scans, then released -> key_valid stays 0 and key_held stays 0.
4. Keys 6 and 9 held together -> no event; FSM returns to IDLE.
5. Event 6 pending without ack; release, then press key 9 -> key_code=9, key_valid=1, overrun=1. key_ack clears both.
6. Reset asserted during DEBOUNCE -> no event ever appears for that press. With KEYPAD_AUTOREPEAT_EN and REPEAT_SCANS=2, a held key re-emits every 2 scans.
